// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
//   Shared types and defaults for the switch debouncer.
//   db_state_t     : debounce FSM states (stable low, settling high,
//                    stable high, settling low).
//   DEFAULT_SETTLE : default settle window in sysclk cycles.
// ---------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;

  localparam int DEFAULT_SETTLE = 16;

endpackage : debounce_pkg

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level (switch or button
//   pin). q follows d two rising edges later.
//   Ports:
//     sysclk : destination clock
//     reset  : asynchronous, active-high reset (both flops load RST_VAL)
//     d      : asynchronous input
//     q      : synchronized output
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic sysclk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule : sync_2ff

// File: rtl/sw_debouncer.sv
// ---------------------------------------------------------------------------
// sw_debouncer
//   Debounces one asynchronous mechanical switch into a clean synchronous
//   level with single-cycle edge ticks, and counts aborted settle attempts.
//   Ports:
//     sysclk     : system clock, all state changes on the rising edge
//     reset      : asynchronous, active-high reset
//     sw_in      : raw switch input, asynchronous to sysclk
//     clr_cnt    : synchronous clear of bounce_cnt (wins over a bounce event)
//     db_level   : debounced level
//     rise_tick  : one-cycle pulse in the first cycle of db_level=1
//     fall_tick  : one-cycle pulse in the first cycle of db_level=0
//     bounce_cnt : saturating count of aborted settle attempts
// ---------------------------------------------------------------------------
module sw_debouncer
  import debounce_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE,  // legal 2..65535
  parameter int BCNT_W        = 8
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              sw_in,
  input  logic              clr_cnt,
  output logic              db_level,
  output logic              rise_tick,
  output logic              fall_tick,
  output logic [BCNT_W-1:0] bounce_cnt
);

  localparam int                CNT_W    = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [BCNT_W-1:0] BCNT_MAX = '1;

  logic              w_sw_sync;

  db_state_t         r_state;
  db_state_t         w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_level;
  logic              r_rise;
  logic              r_fall;
  logic              w_rise_nxt;
  logic              w_fall_nxt;
  logic              w_bounce;
  logic [BCNT_W-1:0] r_bcnt;

  sync_2ff #(
    .RST_VAL (1'b0)
  ) u_sync (
    .sysclk (sysclk),
    .reset  (reset),
    .d      (sw_in),
    .q      (w_sw_sync)
  );

  // -------------------------------------------------------------------------
  // Next-state logic. The entry sample loads SETTLE_CYCLES-1 and the level
  // flips on the sample that finds cnt at 0, so a change is accepted at the
  // (SETTLE_CYCLES+2)-th edge after sw_in was first sampled.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_bounce    = 1'b0;

    unique case (r_state)
      ZERO: begin
        if (w_sw_sync) begin
          w_state_nxt = WAIT1;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT1: begin
        if (!w_sw_sync) begin
          w_state_nxt = ZERO;
          w_bounce    = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_nxt = ONE;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      ONE: begin
        if (!w_sw_sync) begin
          w_state_nxt = WAIT0;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT0: begin
        if (w_sw_sync) begin
          w_state_nxt = ONE;
          w_bounce    = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_nxt = ZERO;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ZERO;
      end
    endcase
  end

  // State, settle counter and registered outputs. The debounced level is
  // derived from the next state so it changes in the same cycle as the tick.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state <= ZERO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= (w_state_nxt == ONE) || (w_state_nxt == WAIT0);
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Bounce event counter: clear has priority, then saturating increment.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_bcnt <= '0;
    end else if (clr_cnt) begin
      r_bcnt <= '0;
    end else if (w_bounce && (r_bcnt != BCNT_MAX)) begin
      r_bcnt <= r_bcnt + BCNT_W'(1);
    end
  end

  assign db_level   = r_level;
  assign rise_tick  = r_rise;
  assign fall_tick  = r_fall;
  assign bounce_cnt = r_bcnt;

endmodule : sw_debouncer
